// File: rtl/if_pkg.sv
// Shared defaults and FSM encoding for the IF-stage PC/fetch controller.
package if_pkg;
  localparam int          WIDTH    = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam int          PC_STEP  = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline latch plus a one-entry hold buffer for a word acked while stalled.
module if_id_reg #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             bubble,
  input  logic             capture,
  input  logic             rel,
  input  logic             squash,
  input  logic [WIDTH-1:0] fetch_npc,
  input  logic [WIDTH-1:0] fetch_instr,
  output logic [WIDTH-1:0] npc,
  output logic [WIDTH-1:0] instr,
  output logic             valid
);
  logic [WIDTH-1:0] hb_npc;
  logic [WIDTH-1:0] hb_instr;

  // Controls are one-hot from the FSM; squash wins when present.
  always_ff @(posedge clk) begin
    if (rst || squash) begin
      npc      <= '0;
      instr    <= NOP;
      valid    <= 1'b0;
      hb_npc   <= '0;
      hb_instr <= NOP;
    end else if (load) begin
      npc   <= fetch_npc;
      instr <= fetch_instr;
      valid <= 1'b1;
    end else if (capture) begin
      hb_npc   <= fetch_npc;
      hb_instr <= fetch_instr;
    end else if (rel) begin
      npc   <= hb_npc;
      instr <= hb_instr;
      valid <= 1'b1;
    end else if (bubble) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/if_pc_ctrl.sv
// IF-stage PC register, PC+4 adder and instruction-fetch FSM feeding the IF/ID latch.
module if_pc_ctrl
  import if_pkg::*;
#(
  parameter int               WIDTH    = if_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = if_pkg::RESET_PC,
  parameter logic [WIDTH-1:0] NOP      = if_pkg::NOP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] next_pc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] if_id_npc,
  output logic [WIDTH-1:0] if_id_instr,
  output logic             if_id_valid
);
  state_t state, state_nxt;
  logic   pc_ld, load, bubble, capture, rel, squash;

  assign pc_plus4 = pc + WIDTH'(PC_STEP);

  always_comb begin
    state_nxt = state;
    pc_ld     = 1'b0;
    load      = 1'b0;
    bubble    = 1'b0;
    capture   = 1'b0;
    rel       = 1'b0;
    squash    = 1'b0;
    if (flush) begin
      // Redirect drops any same-cycle ack and the held word.
      squash    = 1'b1;
      pc_ld     = 1'b1;
      state_nxt = FETCH;
    end else begin
      case (state)
        BOOT: state_nxt = FETCH;
        FETCH: begin
          if (imem_ack && !stall) begin
            load  = 1'b1;
            pc_ld = 1'b1;
          end else if (imem_ack) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end else if (!stall) begin
            bubble = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            rel       = 1'b1;
            pc_ld     = 1'b1;
            state_nxt = FETCH;
          end
        end
        default: state_nxt = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      imem_req <= 1'b0;
    end else begin
      state    <= state_nxt;
      imem_req <= (state_nxt == FETCH);
      if (pc_ld) pc <= {next_pc[WIDTH-1:2], 2'b00};
    end
  end

  if_id_reg #(.WIDTH(WIDTH), .NOP(NOP)) u_if_id (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .bubble      (bubble),
    .capture     (capture),
    .rel         (rel),
    .squash      (squash),
    .fetch_npc   (pc_plus4),
    .fetch_instr (imem_rdata),
    .npc         (if_id_npc),
    .instr       (if_id_instr),
    .valid       (if_id_valid)
  );
endmodule

// File: tb/tb_if_pc_ctrl.sv
// Directed vector bench for if_pc_ctrl: table of per-cycle stimulus and expected state.
module tb_if_pc_ctrl;
  logic        clk = 1'b0;
  logic        rst, imem_ack, stall, flush;
  logic [31:0] next_pc, imem_rdata;
  logic [31:0] pc, pc_plus4, if_id_npc, if_id_instr;
  logic        imem_req, if_id_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_pc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .next_pc     (next_pc),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .flush       (flush),
    .if_id_npc   (if_id_npc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid)
  );

  typedef struct {
    logic        rst, ack, stall, flush;
    logic [31:0] npc_in, rdata;
    logic [31:0] e_pc;
    logic        e_req;
    logic [31:0] e_npc, e_instr;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, a, s, f, input logic [31:0] ni, rd,
                     input logic [31:0] epc, input logic ereq,
                     input logic [31:0] enpc, einstr, input logic evld);
    vec_t v;
    v.rst = r; v.ack = a; v.stall = s; v.flush = f; v.npc_in = ni; v.rdata = rd;
    v.e_pc = epc; v.e_req = ereq; v.e_npc = enpc; v.e_instr = einstr; v.e_valid = evld;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [31:0] epc, input logic ereq,
                           input logic [31:0] enpc, einstr, input logic evld);
    chk("pc", idx, pc, epc);
    chk("pc_plus4", idx, pc_plus4, epc + 32'd4);
    chk("imem_req", idx, {31'd0, imem_req}, {31'd0, ereq});
    chk("if_id_npc", idx, if_id_npc, enpc);
    chk("if_id_instr", idx, if_id_instr, einstr);
    chk("if_id_valid", idx, {31'd0, if_id_valid}, {31'd0, evld});
  endtask

  task automatic drive(input logic r, a, s, f, input logic [31:0] ni, rd);
    @(negedge clk);
    rst = r; imem_ack = a; stall = s; flush = f; next_pc = ni; imem_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] mpc, mnpc, minstr, rd;
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; flush = 1'b0;
    next_pc = '0; imem_rdata = '0;

    //   rst ack stl fl  next_pc       rdata         pc            req npc          instr         vld
    add(1, 1, 0, 0, 32'h4,        32'h0,        32'h0,        0, 32'h0,        32'h0,        0);
    add(1, 1, 0, 0, 32'h4,        32'h0,        32'h0,        0, 32'h0,        32'h0,        0);
    add(0, 1, 0, 0, 32'h4,        32'hBADBAD00, 32'h0,        1, 32'h0,        32'h0,        0);
    add(0, 1, 0, 0, 32'h4,        32'h11111111, 32'h4,        1, 32'h4,        32'h11111111, 1);
    add(0, 1, 0, 0, 32'h8,        32'h22222222, 32'h8,        1, 32'h8,        32'h22222222, 1);
    // acked while stalled at pc=8
    add(0, 1, 1, 0, 32'hC,        32'hA5A5A5A5, 32'h8,        0, 32'h8,        32'h22222222, 1);
    add(0, 1, 1, 0, 32'hC,        32'hDEADBEEF, 32'h8,        0, 32'h8,        32'h22222222, 1);
    add(0, 1, 1, 0, 32'hC,        32'hDEADBEEF, 32'h8,        0, 32'h8,        32'h22222222, 1);
    add(0, 0, 0, 0, 32'hC,        32'hDEADBEEF, 32'hC,        1, 32'hC,        32'hA5A5A5A5, 1);
    add(0, 1, 0, 0, 32'h10,       32'h33333333, 32'h10,       1, 32'h10,       32'h33333333, 1);
    // two wait states at pc=16
    add(0, 0, 0, 0, 32'h14,       32'hDEADBEEF, 32'h10,       1, 32'h10,       32'h33333333, 0);
    add(0, 0, 0, 0, 32'h14,       32'hDEADBEEF, 32'h10,       1, 32'h10,       32'h33333333, 0);
    add(0, 1, 0, 0, 32'h14,       32'h44444444, 32'h14,       1, 32'h14,       32'h44444444, 1);
    add(0, 0, 1, 0, 32'h18,       32'hDEADBEEF, 32'h14,       1, 32'h14,       32'h44444444, 1);
    // flush beats ack and stall
    add(0, 1, 1, 1, 32'h40,       32'h55555555, 32'h40,       1, 32'h0,        32'h0,        0);
    add(0, 1, 0, 0, 32'h44,       32'h66666666, 32'h44,       1, 32'h44,       32'h66666666, 1);
    // unaligned redirect near the top of the address space
    add(0, 0, 0, 1, 32'hFFFFFFFE, 32'h0,        32'hFFFFFFFC, 1, 32'h0,        32'h0,        0);
    add(0, 1, 0, 0, 32'h0,        32'h77777777, 32'h0,        1, 32'h0,        32'h77777777, 1);
    // reset while holding
    add(0, 1, 1, 0, 32'h4,        32'h88888888, 32'h0,        0, 32'h0,        32'h77777777, 1);
    add(1, 0, 1, 0, 32'h4,        32'h0,        32'h0,        0, 32'h0,        32'h0,        0);
    add(0, 1, 0, 0, 32'h4,        32'h0,        32'h0,        1, 32'h0,        32'h0,        0);
    add(0, 1, 0, 0, 32'h4,        32'h99999999, 32'h4,        1, 32'h4,        32'h99999999, 1);
    // flush out of HOLD discards the buffer
    add(0, 1, 1, 0, 32'h8,        32'hAAAA0000, 32'h4,        0, 32'h4,        32'h99999999, 1);
    add(0, 0, 1, 1, 32'h100,      32'h0,        32'h100,      1, 32'h0,        32'h0,        0);
    add(0, 0, 0, 0, 32'h104,      32'h0,        32'h100,      1, 32'h0,        32'h0,        0);
    // reset with an in-flight ack
    add(1, 1, 0, 0, 32'h104,      32'hBBBBBBBB, 32'h0,        0, 32'h0,        32'h0,        0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ack, vecs[i].stall, vecs[i].flush, vecs[i].npc_in, vecs[i].rdata);
      check_all(i, vecs[i].e_pc, vecs[i].e_req, vecs[i].e_npc, vecs[i].e_instr, vecs[i].e_valid);
    end

    // Zero-wait burst after reset: one instruction per cycle, next_pc fed from PC+4.
    drive(0, 1, 0, 0, 32'h4, 32'h0);
    check_all(100, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    mpc = 32'h0;
    for (int k = 0; k < 6; k++) begin
      rd     = $urandom;
      mnpc   = mpc + 32'd4;
      minstr = rd;
      drive(0, 1, 0, 0, mnpc, rd);
      mpc = mnpc;
      check_all(101 + k, mpc, 1'b1, mnpc, minstr, 1'b1);
    end

    // Stall with no ack then ack under stall: bubble-free hold, then one idle cycle on release.
    drive(0, 0, 1, 0, mpc + 32'd4, 32'h0);
    check_all(110, mpc, 1'b1, mnpc, minstr, 1'b1);
    drive(0, 1, 1, 0, mpc + 32'd4, 32'hC0DE0001);
    check_all(111, mpc, 1'b0, mnpc, minstr, 1'b1);
    drive(0, 1, 0, 0, mpc + 32'd4, 32'hFFFF0000);
    check_all(112, mpc + 32'd4, 1'b1, mpc + 32'd4, 32'hC0DE0001, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_pc_ctrl.md
# if_pc_ctrl

Program-counter and fetch controller for the IF stage of the five-stage pipeline. Holds the PC and drives the instruction-memory handshake. Produces PC+4 for the external 32-bit next-PC mux and loads that mux's output back as the next PC. Registers the fetched instruction and PC+4 into the IF/ID latch, with stall and flush control from the hazard unit.

## Interface
- WIDTH, 32, address/data width
- RESET_PC, 32'h00000000, PC value loaded on reset
- NOP, 32'h00000000, instruction word inserted on flush/reset
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous, active-high reset
- next_pc  in  WIDTH  output of the next-PC mux (PC+4 or branch target)
- pc  out  WIDTH  current PC; instruction-memory address
- pc_plus4  out  WIDTH  pc + 4, combinational; feeds next-PC mux input
- imem_req  out  1  fetch request
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  WIDTH  instruction word, valid when imem_ack
- stall  in  1  hazard unit: hold PC and IF/ID
- flush  in  1  hazard unit: squash IF/ID, redirect to next_pc
- if_id_npc  out  WIDTH  registered PC+4 of fetched instruction
- if_id_instr  out  WIDTH  registered instruction
- if_id_valid  out  1  IF/ID contents are a real instruction

## Operation
- States: BOOT, FETCH, HOLD.
- BOOT: imem_req=0. Next cycle goes to FETCH.
- FETCH: imem_req=1 and pc is driven.
  - imem_ack & !stall: IF/ID <= {pc_plus4, imem_rdata, valid=1}; pc <= next_pc. Stay in FETCH.
  - imem_ack & stall: capture imem_rdata and pc_plus4 into a hold buffer. IF/ID and pc are unchanged. Go to HOLD.
  - !imem_ack: pc is unchanged. If !stall, IF/ID valid <= 0 (bubble). If stall, IF/ID is unchanged.
- HOLD: imem_req=0. When stall deasserts, IF/ID <= the hold buffer with valid=1, pc <= next_pc, and the state goes to FETCH.
- flush has priority over stall and ack in every state:
  - IF/ID <= {0, NOP, 0}
  - hold buffer discarded
  - pc <= next_pc
  - state <= FETCH
  - an ack arriving in the same cycle is dropped
- pc loads next_pc with bits [1:0] forced to 0.
- pc_plus4 is modulo 2^WIDTH: 32'hFFFFFFFC gives 32'h00000000.
- The memory samples the address only on the ack cycle. pc may therefore change under an unacknowledged request (flush redirect).

## Timing
- Reset values: pc=RESET_PC, pc_plus4=RESET_PC+4, imem_req=0, if_id_npc=0, if_id_instr=NOP, if_id_valid=0, state=BOOT, hold buffer empty.
- rst asserted mid-operation overrides everything at the next edge. Any in-flight ack is ignored.
- First imem_req is asserted in the 2nd cycle after rst deasserts.
- Zero-wait memory (ack in the same cycle as req) gives 1 instruction/cycle. IF/ID updates at the edge that ends the ack cycle.
- Wait states: N cycles without ack add N bubbles (valid=0).
- Exit from HOLD costs one cycle without a request. The next fetch starts the cycle after the HOLD release.
- All outputs except pc_plus4 are registered.

## Structure
- Package if_pkg holds:
  - WIDTH, NOP, RESET_PC defaults
  - state enum {BOOT, FETCH, HOLD}
  - PC_STEP = 4
- Sub-module if_id_reg holds the IF/ID latch. Its controls are load, squash (flush), hold (stall) and the hold-buffer mux.
- The FSM, PC register and adder stay in the top module.
- The next-PC mux is instantiated outside this block.

## Test plan
- Reset sequence: rst high 2 cycles, then low, imem_ack tied 1, next_pc=pc_plus4.
  - Required: pc = 0, 0 (BOOT), 4, 8.
  - Required: if_id_instr follows imem_rdata; if_id_npc = 4, 8, 12.
- Stall during ack: pc=8, ack=1, stall=1 for 3 cycles, rdata=32'hA5A5A5A5.
  - Required: HOLD entered, pc stays 8, IF/ID unchanged.
  - Required: after release, if_id_instr = A5A5A5A5 with valid=1, then pc=next_pc.
- Flush with ack and stall all high, next_pc=32'h00000040.
  - Required: if_id_valid=0, if_id_instr=NOP, pc=32'h40, state FETCH, fetched word discarded.
- Wait states: ack low 2 cycles at pc=16.
  - Required: two bubbles with valid=0, pc held at 16, imem_req held 1.
- Wrap and alignment:
  - next_pc=32'hFFFFFFFE gives pc=32'hFFFFFFFC and pc_plus4=0.
  - After ack, pc=0.
- Reset mid-HOLD: pc returns to RESET_PC and the hold buffer is cleared. The held instruction never appears at IF/ID.
